id_ex_stage: RTL and testbench

ID/EX pipeline register for the 5-stage RV64 core, sitting between decode/register-read and the EX stage. It produces the registered id_ex_rs1/id_ex_rs2 tags, operands and control bits that the forwarding unit and EX operand muxes consume. It also detects load-use hazards, inserts bubbles, honours flush and hold requests, applies write-back bypass on operand capture, and keeps a bubble performance counter.

---
 rtl/id_ex_stage_pkg.sv | 21 ++
 rtl/id_ex_stage_if.sv | 67 ++++++
 rtl/id_ex_stage_load_use_detector.sv | 23 ++
 rtl/id_ex_stage.sv | 105 ++++++++++
 tb/tb_id_ex_stage.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/id_ex_stage_pkg.sv
// rtl/id_ex_stage_pkg.sv - shared register-tag constants, ALUOp classes and bypass helper
package id_ex_stage_pkg;

    localparam int         XLEN_DEFAULT = 64;
    localparam logic [4:0] REG_ZERO     = 5'd0;

    typedef enum logic [1:0] {
        ALUOP_MEM    = 2'b00,
        ALUOP_BRANCH = 2'b01,
        ALUOP_RTYPE  = 2'b10,
        ALUOP_ITYPE  = 2'b11
    } alu_op_e;

    // x0 is hard-wired, so a write-back to it must never replace read data
    function automatic logic wb_bypass_hit(input logic       wb_we,
                                           input logic [4:0] wb_rd,
                                           input logic [4:0] rs);
        return wb_we && (wb_rd != REG_ZERO) && (wb_rd == rs);
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// rtl/id_ex_stage_if.sv - decode-side fields, WB bypass inputs and registered ID/EX fields
interface id_ex_stage_if #(
    parameter int XLEN = 64
);
    logic            id_valid;
    logic [XLEN-1:0] id_pc;
    logic [4:0]      id_rs1;
    logic [4:0]      id_rs2;
    logic [4:0]      id_rd;
    logic            id_uses_rs1;
    logic            id_uses_rs2;
    logic [XLEN-1:0] id_rs1_data;
    logic [XLEN-1:0] id_rs2_data;
    logic [XLEN-1:0] id_imm;
    logic [3:0]      id_alu_ctrl;
    logic            id_RegWrite;
    logic            id_MemRead;
    logic            id_MemWrite;
    logic            id_MemtoReg;
    logic            id_ALUSrc;
    logic            id_Branch;
    logic [1:0]      id_ALUOp;

    logic            mem_wb_RegWrite;
    logic [4:0]      mem_wb_rd;
    logic [XLEN-1:0] mem_wb_data;

    logic            id_ex_valid;
    logic [XLEN-1:0] id_ex_pc;
    logic [4:0]      id_ex_rs1;
    logic [4:0]      id_ex_rs2;
    logic [4:0]      id_ex_rd;
    logic [XLEN-1:0] id_ex_rs1_data;
    logic [XLEN-1:0] id_ex_rs2_data;
    logic [XLEN-1:0] id_ex_imm;
    logic [3:0]      id_ex_alu_ctrl;
    logic            id_ex_RegWrite;
    logic            id_ex_MemRead;
    logic            id_ex_MemWrite;
    logic            id_ex_MemtoReg;
    logic            id_ex_ALUSrc;
    logic            id_ex_Branch;
    logic [1:0]      id_ex_ALUOp;

    modport master (
        output id_valid, id_pc, id_rs1, id_rs2, id_rd, id_uses_rs1, id_uses_rs2,
               id_rs1_data, id_rs2_data, id_imm, id_alu_ctrl,
               id_RegWrite, id_MemRead, id_MemWrite, id_MemtoReg, id_ALUSrc, id_Branch, id_ALUOp,
               mem_wb_RegWrite, mem_wb_rd, mem_wb_data,
        input  id_ex_valid, id_ex_pc, id_ex_rs1, id_ex_rs2, id_ex_rd,
               id_ex_rs1_data, id_ex_rs2_data, id_ex_imm, id_ex_alu_ctrl,
               id_ex_RegWrite, id_ex_MemRead, id_ex_MemWrite, id_ex_MemtoReg,
               id_ex_ALUSrc, id_ex_Branch, id_ex_ALUOp
    );

    modport slave (
        input  id_valid, id_pc, id_rs1, id_rs2, id_rd, id_uses_rs1, id_uses_rs2,
               id_rs1_data, id_rs2_data, id_imm, id_alu_ctrl,
               id_RegWrite, id_MemRead, id_MemWrite, id_MemtoReg, id_ALUSrc, id_Branch, id_ALUOp,
               mem_wb_RegWrite, mem_wb_rd, mem_wb_data,
        output id_ex_valid, id_ex_pc, id_ex_rs1, id_ex_rs2, id_ex_rd,
               id_ex_rs1_data, id_ex_rs2_data, id_ex_imm, id_ex_alu_ctrl,
               id_ex_RegWrite, id_ex_MemRead, id_ex_MemWrite, id_ex_MemtoReg,
               id_ex_ALUSrc, id_ex_Branch, id_ex_ALUOp
    );

endinterface

// File: rtl/id_ex_stage_load_use_detector.sv
// rtl/id_ex_stage_load_use_detector.sv - combinational load-use hazard check between ID/EX and ID
module load_use_detector
    import id_ex_stage_pkg::*;
(
    input  logic       ex_valid,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rd,
    input  logic       id_valid,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    output logic       load_use
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit  = id_uses_rs1 && (id_rs1 == ex_rd);
    assign rs2_hit  = id_uses_rs2 && (id_rs2 == ex_rd);
    assign load_use = ex_valid && ex_mem_read && (ex_rd != REG_ZERO) && id_valid && (rs1_hit || rs2_hit);

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use bubbles, flush/hold and WB bypass
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             hold,
    output logic             stall_if_id,
    output logic [CNT_W-1:0] bubble_count,
    id_ex_stage_if.slave     bus
);

    logic load_use;
    logic insert_bubble;
    logic cnt_sat;
    logic ctl_en;

    load_use_detector u_load_use_detector (
        .ex_valid    (bus.id_ex_valid),
        .ex_mem_read (bus.id_ex_MemRead),
        .ex_rd       (bus.id_ex_rd),
        .id_valid    (bus.id_valid),
        .id_rs1      (bus.id_rs1),
        .id_rs2      (bus.id_rs2),
        .id_uses_rs1 (bus.id_uses_rs1),
        .id_uses_rs2 (bus.id_uses_rs2),
        .load_use    (load_use)
    );

    // a flush already discards ID, and a hold freezes everything, so neither needs IF/ID frozen
    assign stall_if_id   = load_use && !flush && !hold;
    assign insert_bubble = flush || (!hold && load_use);
    assign cnt_sat       = (bubble_count == {CNT_W{1'b1}});
    assign ctl_en        = bus.id_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.id_ex_valid    <= 1'b0;
            bus.id_ex_pc       <= '0;
            bus.id_ex_rs1      <= '0;
            bus.id_ex_rs2      <= '0;
            bus.id_ex_rd       <= '0;
            bus.id_ex_rs1_data <= '0;
            bus.id_ex_rs2_data <= '0;
            bus.id_ex_imm      <= '0;
            bus.id_ex_alu_ctrl <= '0;
            bus.id_ex_RegWrite <= 1'b0;
            bus.id_ex_MemRead  <= 1'b0;
            bus.id_ex_MemWrite <= 1'b0;
            bus.id_ex_MemtoReg <= 1'b0;
            bus.id_ex_ALUSrc   <= 1'b0;
            bus.id_ex_Branch   <= 1'b0;
            bus.id_ex_ALUOp    <= '0;
        end else if (insert_bubble) begin
            bus.id_ex_valid    <= 1'b0;
            bus.id_ex_pc       <= '0;
            bus.id_ex_rs1      <= '0;
            bus.id_ex_rs2      <= '0;
            bus.id_ex_rd       <= '0;
            bus.id_ex_rs1_data <= '0;
            bus.id_ex_rs2_data <= '0;
            bus.id_ex_imm      <= '0;
            bus.id_ex_alu_ctrl <= '0;
            bus.id_ex_RegWrite <= 1'b0;
            bus.id_ex_MemRead  <= 1'b0;
            bus.id_ex_MemWrite <= 1'b0;
            bus.id_ex_MemtoReg <= 1'b0;
            bus.id_ex_ALUSrc   <= 1'b0;
            bus.id_ex_Branch   <= 1'b0;
            bus.id_ex_ALUOp    <= '0;
        end else if (!hold) begin
            bus.id_ex_valid    <= bus.id_valid;
            bus.id_ex_pc       <= bus.id_pc;
            bus.id_ex_rs1      <= bus.id_rs1;
            bus.id_ex_rs2      <= bus.id_rs2;
            bus.id_ex_rd       <= bus.id_rd;
            bus.id_ex_rs1_data <= wb_bypass_hit(bus.mem_wb_RegWrite, bus.mem_wb_rd, bus.id_rs1)
                                  ? bus.mem_wb_data : bus.id_rs1_data;
            bus.id_ex_rs2_data <= wb_bypass_hit(bus.mem_wb_RegWrite, bus.mem_wb_rd, bus.id_rs2)
                                  ? bus.mem_wb_data : bus.id_rs2_data;
            bus.id_ex_imm      <= bus.id_imm;
            bus.id_ex_alu_ctrl <= bus.id_alu_ctrl;
            bus.id_ex_RegWrite <= bus.id_RegWrite && ctl_en;
            bus.id_ex_MemRead  <= bus.id_MemRead  && ctl_en;
            bus.id_ex_MemWrite <= bus.id_MemWrite && ctl_en;
            bus.id_ex_MemtoReg <= bus.id_MemtoReg && ctl_en;
            bus.id_ex_ALUSrc   <= bus.id_ALUSrc   && ctl_en;
            bus.id_ex_Branch   <= bus.id_Branch   && ctl_en;
            bus.id_ex_ALUOp    <= bus.id_ALUOp;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bubble_count <= '0;
        end else if (insert_bubble && !cnt_sat) begin
            bubble_count <= bubble_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - randomized and directed checks of id_ex_stage against a behavioural model
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    localparam int XLEN  = 64;
    localparam int CNT_W = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             flush;
    logic             hold;
    logic             stall_if_id;
    logic [CNT_W-1:0] bubble_count;

    always #5 clk = ~clk;

    id_ex_stage_if #(.XLEN(XLEN)) bus ();

    id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .hold         (hold),
        .stall_if_id  (stall_if_id),
        .bubble_count (bubble_count),
        .bus          (bus)
    );

    int checks = 0;
    int errors = 0;

    // expected contents of the ID/EX register
    logic            m_valid;
    logic [XLEN-1:0] m_pc, m_d1, m_d2, m_imm;
    logic [4:0]      m_rs1, m_rs2, m_rd;
    logic [3:0]      m_alu_ctrl;
    logic [5:0]      m_ctl;   // RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, Branch
    logic [1:0]      m_aluop;
    int              m_cnt;
    logic            last_stall;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [XLEN-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic model_clear();
        m_valid = 1'b0; m_pc = '0; m_d1 = '0; m_d2 = '0; m_imm = '0;
        m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_alu_ctrl = '0; m_ctl = '0; m_aluop = '0;
    endtask

    // the instruction in EX is a load whose result the ID instruction needs next cycle
    function automatic logic model_hazard();
        logic needs;
        needs = (bus.id_uses_rs1 && bus.id_rs1 == m_rd) || (bus.id_uses_rs2 && bus.id_rs2 == m_rd);
        return m_valid && m_ctl[4] && (m_rd != 5'd0) && bus.id_valid && needs;
    endfunction

    task automatic model_edge(input logic lu);
        if (flush || (!hold && lu)) begin
            model_clear();
            if (m_cnt < CNT_MAX) m_cnt++;
        end else if (!hold) begin
            m_valid    = bus.id_valid;
            m_pc       = bus.id_pc;
            m_rs1      = bus.id_rs1;
            m_rs2      = bus.id_rs2;
            m_rd       = bus.id_rd;
            m_imm      = bus.id_imm;
            m_alu_ctrl = bus.id_alu_ctrl;
            m_aluop    = bus.id_ALUOp;
            m_ctl      = bus.id_valid ? {bus.id_RegWrite, bus.id_MemRead, bus.id_MemWrite,
                                         bus.id_MemtoReg, bus.id_ALUSrc, bus.id_Branch} : 6'b0;
            m_d1 = (bus.mem_wb_RegWrite && bus.mem_wb_rd != 0 && bus.mem_wb_rd == bus.id_rs1)
                   ? bus.mem_wb_data : bus.id_rs1_data;
            m_d2 = (bus.mem_wb_RegWrite && bus.mem_wb_rd != 0 && bus.mem_wb_rd == bus.id_rs2)
                   ? bus.mem_wb_data : bus.id_rs2_data;
        end
    endtask

    task automatic check_outputs();
        check("valid", 256'(bus.id_ex_valid), 256'(m_valid));
        check("ctl", 256'({bus.id_ex_RegWrite, bus.id_ex_MemRead, bus.id_ex_MemWrite,
                           bus.id_ex_MemtoReg, bus.id_ex_ALUSrc, bus.id_ex_Branch}), 256'(m_ctl));
        check("alu", 256'({bus.id_ex_ALUOp, bus.id_ex_alu_ctrl}), 256'({m_aluop, m_alu_ctrl}));
        check("tags", 256'({bus.id_ex_rs1, bus.id_ex_rs2, bus.id_ex_rd}), 256'({m_rs1, m_rs2, m_rd}));
        check("pc_imm", 256'({bus.id_ex_pc, bus.id_ex_imm}), 256'({m_pc, m_imm}));
        check("rs1_data", 256'(bus.id_ex_rs1_data), 256'(m_d1));
        check("rs2_data", 256'(bus.id_ex_rs2_data), 256'(m_d2));
        check("bubble_count", 256'(bubble_count), 256'(m_cnt));
    endtask

    // inputs are already applied; check the combinational stall, then clock one edge
    task automatic step();
        logic lu;
        logic exp_stall;
        #1;
        lu        = model_hazard();
        exp_stall = lu && !flush && !hold;
        check("stall_if_id", 256'(stall_if_id), 256'(exp_stall));
        last_stall = exp_stall;
        model_edge(lu);
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic set_instr(input logic v, input logic [4:0] rd, input logic [4:0] rs1,
                             input logic [4:0] rs2, input logic u1, input logic u2,
                             input logic [5:0] ctl, input logic [1:0] aluop);
        bus.id_valid    = v;
        bus.id_pc       = rnd64();
        bus.id_rd       = rd;
        bus.id_rs1      = rs1;
        bus.id_rs2      = rs2;
        bus.id_uses_rs1 = u1;
        bus.id_uses_rs2 = u2;
        bus.id_rs1_data = rnd64();
        bus.id_rs2_data = rnd64();
        bus.id_imm      = rnd64();
        bus.id_alu_ctrl = 4'($urandom_range(0, 15));
        {bus.id_RegWrite, bus.id_MemRead, bus.id_MemWrite,
         bus.id_MemtoReg, bus.id_ALUSrc, bus.id_Branch} = ctl;
        bus.id_ALUOp    = aluop;
    endtask

    task automatic wb_off();
        bus.mem_wb_RegWrite = 1'b0;
        bus.mem_wb_rd       = 5'd0;
        bus.mem_wb_data     = '0;
    endtask

    localparam logic [5:0] CTL_LD  = 6'b110110;
    localparam logic [5:0] CTL_ADD = 6'b100000;
    localparam logic [5:0] CTL_SW  = 6'b001010;

    int cnt_before;
    logic keep;

    initial begin
        reset = 1'b1; flush = 1'b0; hold = 1'b0;
        set_instr(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 6'b0, ALUOP_MEM);
        wb_off();
        model_clear();
        m_cnt = 0;
        last_stall = 1'b0;
        @(posedge clk); #1;
        check_outputs();
        check("reset_stall", 256'(stall_if_id), 256'(0));
        reset = 1'b0;
        step();
        step();

        // ld x5 then add x6,x5,x7: one bubble, then add captured
        set_instr(1'b1, 5'd5, 5'd1, 5'd0, 1'b1, 1'b0, CTL_LD, ALUOP_MEM);
        step();
        set_instr(1'b1, 5'd6, 5'd5, 5'd7, 1'b1, 1'b1, CTL_ADD, ALUOP_RTYPE);
        step();
        check("ld_use_stall", 256'(last_stall), 256'(1));
        check("ld_use_bubble", 256'({bus.id_ex_valid, bubble_count}), 256'({1'b0, 4'd1}));
        step();
        check("ld_use_capture", 256'({bus.id_ex_valid, bus.id_ex_rs1}), 256'({1'b1, 5'd5}));

        // ld x0 never hazards
        set_instr(1'b1, 5'd0, 5'd2, 5'd0, 1'b1, 1'b0, CTL_LD, ALUOP_MEM);
        step();
        set_instr(1'b1, 5'd6, 5'd0, 5'd0, 1'b1, 1'b1, CTL_ADD, ALUOP_RTYPE);
        step();
        check("ld_x0_nostall", 256'(last_stall), 256'(0));

        // store reading only rs2 with a stale rs1 field matching the load
        set_instr(1'b1, 5'd5, 5'd1, 5'd0, 1'b1, 1'b0, CTL_LD, ALUOP_MEM);
        step();
        set_instr(1'b1, 5'd5, 5'd5, 5'd9, 1'b0, 1'b1, CTL_SW, ALUOP_MEM);
        step();
        check("sw_rs1_unused", 256'(last_stall), 256'(0));

        // write-back bypass on both operands
        set_instr(1'b1, 5'd8, 5'd3, 5'd3, 1'b1, 1'b1, CTL_ADD, ALUOP_RTYPE);
        bus.id_rs1_data = 64'h1111; bus.id_rs2_data = 64'h2222;
        bus.mem_wb_RegWrite = 1'b1; bus.mem_wb_rd = 5'd3; bus.mem_wb_data = 64'hDEAD_BEEF;
        step();
        check("wb_bypass", 256'({bus.id_ex_rs1_data, bus.id_ex_rs2_data}),
              256'({64'hDEAD_BEEF, 64'hDEAD_BEEF}));
        wb_off();

        // flush coinciding with load-use
        set_instr(1'b1, 5'd5, 5'd1, 5'd0, 1'b1, 1'b0, CTL_LD, ALUOP_MEM);
        step();
        cnt_before = m_cnt;
        set_instr(1'b1, 5'd6, 5'd5, 5'd7, 1'b1, 1'b1, CTL_ADD, ALUOP_RTYPE);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_lu_stall", 256'(last_stall), 256'(0));
        check("flush_lu_count", 256'(bubble_count), 256'(cnt_before + 1));

        // hold for 3 cycles with a live hazard
        set_instr(1'b1, 5'd5, 5'd1, 5'd0, 1'b1, 1'b0, CTL_LD, ALUOP_MEM);
        step();
        cnt_before = m_cnt;
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_instr(1'b1, 5'd6, 5'd5, 5'd7, 1'b1, 1'b1, CTL_ADD, ALUOP_RTYPE);
            step();
            check("hold_frozen", 256'({bus.id_ex_valid, bus.id_ex_rd, bubble_count}),
                  256'({1'b1, 5'd5, 4'(cnt_before)}));
        end
        hold = 1'b0;
        step();

        // randomized traffic
        keep = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!keep) begin
                set_instr($urandom_range(0, 7) != 0, 5'($urandom_range(0, 7)),
                          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                          1'($urandom), 1'($urandom), 6'($urandom),
                          2'($urandom));
            end
            flush = ($urandom_range(0, 9) == 0);
            hold  = ($urandom_range(0, 7) == 0);
            bus.mem_wb_RegWrite = 1'($urandom);
            bus.mem_wb_rd       = 5'($urandom_range(0, 7));
            bus.mem_wb_data     = rnd64();
            step();
            keep = last_stall || hold;
        end
        flush = 1'b0; hold = 1'b0;
        wb_off();

        // counter saturation
        flush = 1'b1;
        for (int i = 0; i < 20; i++) step();
        flush = 1'b0;
        check("cnt_saturated", 256'(bubble_count), 256'(CNT_MAX));

        // reset asserted mid-stall clears without a clock edge
        set_instr(1'b1, 5'd5, 5'd1, 5'd0, 1'b1, 1'b0, CTL_LD, ALUOP_MEM);
        step();
        set_instr(1'b1, 5'd6, 5'd5, 5'd7, 1'b1, 1'b1, CTL_ADD, ALUOP_RTYPE);
        hold = 1'b1;
        step();
        hold = 1'b0;
        #1;
        check("stall_before_reset", 256'(stall_if_id), 256'(1));
        reset = 1'b1;
        #1;
        model_clear();
        m_cnt = 0;
        check("async_reset_stall", 256'(stall_if_id), 256'(0));
        check("async_reset_state", 256'({bus.id_ex_valid, bus.id_ex_MemRead, bus.id_ex_rd, bubble_count}),
              256'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        set_instr(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 6'b0, ALUOP_MEM);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
